// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: freezes fetch on a tag miss, reads one cache line from memory, streams its beats into the icache and writes the tag.
module icache_refill_ctrl #(
  parameter int BEATS = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             miss,
  input  logic [31:0]      pc,
  output logic             stall,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic             mem_ready,
  input  logic             mem_valid,
  input  logic [63:0]      mem_data,
  output logic             fill,
  output logic [4:0]       fill_idx,
  output logic [63:0]      stream,
  output logic             tag_write,
  output logic [4:0]       tag_idx,
  output logic [23:0]      tag_val,
  output logic             busy,
  output logic [CNT_W-1:0] refill_cnt
);
  localparam int BW = $clog2(BEATS);
  typedef enum logic [2:0] {IDLE, REQ, RECV, TAG, WAIT} state_t;
  state_t state, state_nx;
  logic [BW-1:0] beat;
  logic [31:0] line_pc;
  logic take;
  always_comb begin
    state_nx = state;
    take = state == RECV && mem_valid;
    unique case (state)
      IDLE: state_nx = miss ? REQ : IDLE;
      REQ:  state_nx = mem_ready ? RECV : REQ;
      RECV: state_nx = (take && beat == BW'(BEATS - 1)) ? TAG : RECV;
      TAG:  state_nx = WAIT;
      default: state_nx = IDLE;
    endcase
    busy = state != IDLE;
    stall = (state == IDLE && miss) || busy;
    mem_req = state == REQ;
    mem_addr = line_pc;
    tag_idx = line_pc[9:5];
    tag_val = line_pc[31:8];
  end
  // tag_write is delayed one cycle so it never collides with the final fill pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      beat <= '0;
      line_pc <= '0;
      refill_cnt <= '0;
      fill <= 1'b0;
      fill_idx <= '0;
      stream <= '0;
      tag_write <= 1'b0;
    end else begin
      state <= state_nx;
      fill <= take;
      tag_write <= state == TAG;
      if (state == IDLE && miss) begin
        line_pc <= pc & 32'hFFFF_FFE0;
        beat <= '0;
      end
      if (take) begin
        stream <= mem_data;
        fill_idx <= {line_pc[7:5], 2'(beat)};
        beat <= beat + 1'b1;
      end
      if (state == TAG && refill_cnt != '1) refill_cnt <= refill_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl: directed refill scenarios with hand-computed line, index, tag and latency expectations.
module tb_icache_refill_ctrl;
  logic clk = 0, rst_n, miss, mem_ready, mem_valid;
  logic [31:0] pc, mem_addr;
  logic [63:0] mem_data, stream;
  logic stall, mem_req, fill, tag_write, busy;
  logic [4:0] fill_idx, tag_idx;
  logic [23:0] tag_val;
  logic [1:0] refill_cnt;
  int checks = 0, failures = 0;
  int tw_n = 0, hs_n = 0, st_n = 0, ovl_n = 0;
  logic [4:0] tw_idx;
  logic [23:0] tw_val;
  logic [4:0] fq_idx[$];
  logic [63:0] fq_dat[$];

  icache_refill_ctrl #(.BEATS(4), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .miss(miss), .pc(pc), .stall(stall),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_valid(mem_valid), .mem_data(mem_data), .fill(fill),
    .fill_idx(fill_idx), .stream(stream), .tag_write(tag_write),
    .tag_idx(tag_idx), .tag_val(tag_val), .busy(busy), .refill_cnt(refill_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fill) begin fq_idx.push_back(fill_idx); fq_dat.push_back(stream); end
    if (tag_write) begin tw_n++; tw_idx = tag_idx; tw_val = tag_val; end
    if (mem_req && mem_ready) hs_n++;
    if (stall) st_n++;
    if (fill && tag_write) ovl_n++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] beat_data(input logic [31:0] p, input int k);
    return {p ^ 32'h5A5A_0000, 24'hDA7A00, 8'(k)};
  endfunction

  task automatic refill(input logic [31:0] p, input int rdy_wait, input logic [15:0] vpat,
                        input int vlen, input logic spur);
    logic [31:0] line;
    int tw0, hs0, st0, k;
    line = p & 32'hFFFF_FFE0;
    fq_idx.delete();
    fq_dat.delete();
    tw0 = tw_n; hs0 = hs_n; st0 = st_n;
    pc = p; miss = 1; mem_ready = 0; mem_valid = 0;
    @(posedge clk); #1;
    miss = 0;
    check("req_addr", mem_addr, line);
    for (int i = 0; i < rdy_wait; i++) begin
      mem_valid = spur;
      check("req_held", mem_req, 1);
      check("addr_held", mem_addr, line);
      @(posedge clk); #1;
    end
    mem_ready = 1;
    @(posedge clk); #1;
    mem_ready = 0; mem_valid = 0;
    check("one_handshake", hs_n - hs0, 1);
    check("no_early_fill", fq_idx.size(), 0);
    k = 0;
    for (int i = 0; i < vlen; i++) begin
      mem_valid = vpat[i];
      mem_data = vpat[i] ? beat_data(p, k) : 64'hBAD0_BAD0_BAD0_BAD0;
      if (vpat[i]) k++;
      pc = ~pc;
      @(posedge clk); #1;
    end
    mem_valid = 0;
    check("no_early_tag", tw_n - tw0, 0);
    for (int i = 0; i < 20 && busy; i++) begin @(posedge clk); #1; end
    check("back_idle", busy, 0);
    check("stall_released", stall, 0);
    check("stall_cycles", st_n - st0, rdy_wait + vlen + 4);
    check("fill_count", fq_idx.size(), 4);
    for (int j = 0; j < 4 && j < fq_idx.size(); j++) begin
      check("fill_idx", fq_idx[j], {line[7:5], 2'(j)});
      check("fill_data", fq_dat[j], beat_data(p, j));
    end
    check("tag_once", tw_n - tw0, 1);
    check("tag_idx", tw_idx, line[9:5]);
    check("tag_val", tw_val, line[31:8]);
  endtask

  initial begin
    rst_n = 0; miss = 1; pc = 32'h0000_4000;
    mem_ready = 0; mem_valid = 0; mem_data = '0;
    #3;
    check("rst_stall", stall, 1);
    check("rst_busy", busy, 0);
    check("rst_req", mem_req, 0);
    check("rst_cnt", refill_cnt, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    miss = 0; mem_ready = 1;
    check("mid_req", mem_req, 1);
    @(posedge clk); #1;
    mem_ready = 0; mem_valid = 1; mem_data = 64'h1111;
    @(posedge clk); #1;
    mem_data = 64'h2222;
    @(posedge clk); #1;
    mem_valid = 0;
    check("mid_fill", fill, 1);
    #2 rst_n = 0;
    #1;
    check("arst_fill", fill, 0);
    check("arst_busy", busy, 0);
    check("arst_stall", stall, 0);
    check("arst_stream", stream, 0);
    check("arst_idx", fill_idx, 0);
    repeat (3) @(posedge clk);
    #1;
    check("arst_no_tag", tw_n, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    check("arst_cnt", refill_cnt, 0);

    refill(32'h0000_1234, 0, 16'b1111, 4, 0);
    check("cnt1", refill_cnt, 1);

    mem_valid = 1; mem_data = 64'hDEAD;
    @(posedge clk); #1;
    mem_valid = 0;
    check("idle_spur", fq_idx.size() + 0, 4);
    refill(32'h8765_43A8, 5, 16'b1111, 4, 1);
    check("cnt2", refill_cnt, 2);

    refill(32'hFFFF_FFE4, 0, 16'b1101001, 7, 0);
    check("cnt3", refill_cnt, 3);
    refill(32'h0000_0100, 1, 16'b1111, 4, 0);
    check("cnt_sat4", refill_cnt, 3);
    refill(32'h0000_03E0, 0, 16'b10111, 5, 0);
    check("cnt_sat5", refill_cnt, 3);

    check("fill_tag_overlap", ovl_n, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
